// File: rtl/brlite_local_ni_pkg.sv
// BrLite shared types plus the local network-interface FSM state encodings.
package BrLitePkg;

    typedef enum logic [1:0] {
        BR_SVC_ALL = 2'd0,
        BR_SVC_TGT = 2'd1,
        BR_SVC_MON = 2'd2,
        BR_SVC_CLR = 2'd3
    } br_svc_t;

    localparam int unsigned BR_LOCAL = 4;

    typedef struct packed {
        br_svc_t     service;
        logic [7:0]  id;
        logic [7:0]  src;
        logic [15:0] payload;
    } br_data_t;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'b001,
        TX_REQ     = 3'b010,
        TX_RELEASE = 3'b100
    } brlite_ni_tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE = 3'b001,
        RX_ACK  = 3'b010,
        RX_WAIT = 3'b100
    } brlite_ni_rx_state_t;

endpackage

// File: rtl/brlite_fifo.sv
// Receive FIFO for the local NI; extra pointer MSB distinguishes full from empty.
module brlite_fifo
    import BrLitePkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  br_data_t data_i,
    input  logic     pop_i,
    output br_data_t data_o,
    output logic     full_o,
    output logic     empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    br_data_t    mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/brlite_local_ni.sv
// BrLite local network interface: PE<->router req/ack bridge with a receive FIFO.
// Define BRLITE_NI_STATS_EN to add tx_cnt_o/rx_cnt_o transfer counters.
module brlite_local_ni
    import BrLitePkg::*;
#(
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     tx_valid_i,
    output logic     tx_ready_o,
    input  br_data_t tx_data_i,
    output logic     rx_valid_o,
    input  logic     rx_ready_i,
    output br_data_t rx_data_o,
    output br_data_t br_flit_o,
    output logic     br_req_o,
    input  logic     br_ack_i,
    input  br_data_t br_flit_i,
    input  logic     br_req_i,
    output logic     br_ack_o,
    input  logic     br_busy_i
`ifdef BRLITE_NI_STATS_EN
    ,
    output logic [15:0] tx_cnt_o,
    output logic [15:0] rx_cnt_o
`endif
);
    // TX: state      | meaning
    //     TX_IDLE    | ready for a PE flit unless router local broadcast pending
    //     TX_REQ     | req held to router until acked (no timeout)
    //     TX_RELEASE | req dropped, waiting for router ack to fall
    // RX: RX_IDLE    | waiting for router req and FIFO space; push on entry to ACK
    //     RX_ACK     | ack high for one cycle
    //     RX_WAIT    | waiting for router req to fall
    brlite_ni_tx_state_t tx_state_q, tx_state_d;
    brlite_ni_rx_state_t rx_state_q, rx_state_d;
    br_data_t            hold_q, hold_d;
    logic                run_q;
    logic                fifo_full;
    logic                fifo_empty;
    logic                rx_push;
    logic                rx_pop;

    // run_q keeps tx_ready_o low while reset is asserted, since it depends on br_busy_i.
    assign tx_ready_o = run_q && (tx_state_q == TX_IDLE) && !br_busy_i;
    assign br_req_o   = (tx_state_q == TX_REQ);
    assign br_flit_o  = hold_q;
    assign br_ack_o   = (rx_state_q == RX_ACK);
    assign rx_valid_o = !fifo_empty;
    assign rx_push    = (rx_state_q == RX_IDLE) && br_req_i && !fifo_full;
    assign rx_pop     = rx_valid_o && rx_ready_i;

    always_comb begin
        tx_state_d = tx_state_q;
        hold_d     = hold_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid_i && tx_ready_o) begin
                    hold_d     = tx_data_i;
                    tx_state_d = TX_REQ;
                end
            end
            TX_REQ:     if (br_ack_i)  tx_state_d = TX_RELEASE;
            TX_RELEASE: if (!br_ack_i) tx_state_d = TX_IDLE;
            default:    tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            RX_IDLE: if (rx_push)   rx_state_d = RX_ACK;
            RX_ACK:                 rx_state_d = RX_WAIT;
            RX_WAIT: if (!br_req_i) rx_state_d = RX_IDLE;
            default:                rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_q <= TX_IDLE;
            rx_state_q <= RX_IDLE;
            run_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            run_q      <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        hold_q <= hold_d;
    end

    brlite_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rx_push),
        .data_i  (br_flit_i),
        .pop_i   (rx_pop),
        .data_o  (rx_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef BRLITE_NI_STATS_EN
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        if ((tx_state_q == TX_REQ) && br_ack_i) tx_cnt_d = tx_cnt_q + 16'd1;
        if (rx_push)                            rx_cnt_d = rx_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    assign tx_cnt_o = tx_cnt_q;
    assign rx_cnt_o = rx_cnt_q;
`endif

endmodule

// File: tb/tb_brlite_local_ni.sv
// Directed bench for brlite_local_ni: vector table plus hand-written multi-cycle sequences.
module tb_brlite_local_ni;
    import BrLitePkg::*;

    logic     clk_i = 1'b0;
    logic     rst_ni = 1'b0;
    logic     tx_valid_i;
    logic     tx_ready_o;
    br_data_t tx_data_i;
    logic     rx_valid_o;
    logic     rx_ready_i;
    br_data_t rx_data_o;
    br_data_t br_flit_o;
    logic     br_req_o;
    logic     br_ack_i;
    br_data_t br_flit_i;
    logic     br_req_i;
    logic     br_ack_o;
    logic     br_busy_i;
`ifdef BRLITE_NI_STATS_EN
    logic [15:0] tx_cnt_o;
    logic [15:0] rx_cnt_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    brlite_local_ni #(.RX_DEPTH(4)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .tx_data_i  (tx_data_i),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .rx_data_o  (rx_data_o),
        .br_flit_o  (br_flit_o),
        .br_req_o   (br_req_o),
        .br_ack_i   (br_ack_i),
        .br_flit_i  (br_flit_i),
        .br_req_i   (br_req_i),
        .br_ack_o   (br_ack_o),
        .br_busy_i  (br_busy_i)
`ifdef BRLITE_NI_STATS_EN
        ,
        .tx_cnt_o   (tx_cnt_o),
        .rx_cnt_o   (rx_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       tv, busy, ack, rreq;
        logic [7:0] rid;
        logic       rrdy;
        logic       e_trdy, e_breq, e_back, e_rval;
        logic [7:0] e_rid;
        logic       chk_flit;
    } vec_t;

    vec_t vt[19];

    function automatic vec_t mk(input logic tv, busy, ack, rreq, input logic [7:0] rid,
                                input logic rrdy, e_trdy, e_breq, e_back, e_rval,
                                input logic [7:0] e_rid, input logic chk_flit);
        vec_t v;
        v.tv = tv; v.busy = busy; v.ack = ack; v.rreq = rreq; v.rid = rid; v.rrdy = rrdy;
        v.e_trdy = e_trdy; v.e_breq = e_breq; v.e_back = e_back; v.e_rval = e_rval;
        v.e_rid = e_rid; v.chk_flit = chk_flit;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    // Router side: wait (bounded) for br_ack_o, then drop br_req_i and let RX return to idle.
    task automatic rtr_wait(input int budget, output logic got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (br_ack_o) begin
                got = 1'b1;
                break;
            end
            @(posedge clk_i);
            #2;
        end
        if (got) begin
            br_req_i = 1'b0;
            tick();
            tick();
        end
    endtask

    br_data_t pkt_a, pkt_b, pkt_c;
    logic     got;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_a = '{service: BR_SVC_ALL, id: 8'd1, src: 8'(BR_LOCAL), payload: 16'h00AB};
        pkt_b = '{service: BR_SVC_TGT, id: 8'd2, src: 8'(BR_LOCAL), payload: 16'h1234};
        pkt_c = '{service: BR_SVC_CLR, id: 8'd3, src: 8'(BR_LOCAL), payload: 16'h5A5A};

        //            tv bs ak rq rid rr  trdy breq back rval erid flit
        vt[0]  = mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        vt[1]  = mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1);
        vt[2]  = mk(0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 1);
        vt[3]  = mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        vt[4]  = mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        vt[5]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        vt[6]  = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1);
        vt[7]  = mk(0, 0, 0, 1, 5, 0,  1, 0, 0, 0, 0, 0);
        vt[8]  = mk(0, 0, 0, 1, 5, 0,  1, 0, 1, 1, 5, 0);
        vt[9]  = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 5, 0);
        vt[10] = mk(0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 5, 0);
        vt[11] = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        vt[12] = mk(1, 0, 0, 1, 9, 0,  1, 0, 0, 0, 0, 0);
        vt[13] = mk(0, 0, 1, 1, 9, 0,  0, 1, 1, 1, 9, 1);
        vt[14] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 9, 1);
        vt[15] = mk(0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 9, 0);
        vt[16] = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        vt[17] = mk(1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        vt[18] = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1);

        tx_valid_i = 1'b0;
        tx_data_i  = pkt_a;
        rx_ready_i = 1'b0;
        br_ack_i   = 1'b0;
        br_flit_i  = '0;
        br_req_i   = 1'b0;
        br_busy_i  = 1'b0;

        // Reset state: outputs low even though br_busy_i=0
        #12;
        chk("rst_tx_ready", tx_ready_o, 1'b0);
        chk("rst_br_req",   br_req_o,   1'b0);
        chk("rst_br_ack",   br_ack_o,   1'b0);
        chk("rst_rx_valid", rx_valid_o, 1'b0);
        rst_ni = 1'b1;
        tick();

        for (int i = 0; i < 19; i++) begin
            tx_valid_i   = vt[i].tv;
            br_busy_i    = vt[i].busy;
            br_ack_i     = vt[i].ack;
            br_req_i     = vt[i].rreq;
            br_flit_i    = '0;
            br_flit_i.id = vt[i].rid;
            rx_ready_i   = vt[i].rrdy;
            #1;
            chk($sformatf("v%0d_tx_ready", i), tx_ready_o, vt[i].e_trdy);
            chk($sformatf("v%0d_br_req", i),   br_req_o,   vt[i].e_breq);
            chk($sformatf("v%0d_br_ack", i),   br_ack_o,   vt[i].e_back);
            chk($sformatf("v%0d_rx_valid", i), rx_valid_o, vt[i].e_rval);
            if (vt[i].e_rval) chk($sformatf("v%0d_rx_id", i), rx_data_o.id, vt[i].e_rid);
            if (vt[i].chk_flit) chk($sformatf("v%0d_br_flit", i), br_flit_o, pkt_a);
            tick();
        end
        tx_valid_i = 1'b0;
        br_busy_i  = 1'b0;
        br_ack_i   = 1'b0;
        br_req_i   = 1'b0;
        rx_ready_i = 1'b0;

        // Busy router blocks acceptance for 50 cycles, then accepts immediately
        tx_data_i  = pkt_b;
        tx_valid_i = 1'b1;
        br_busy_i  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            chk("busy_tx_ready", tx_ready_o, 1'b0);
            chk("busy_br_req",   br_req_o,   1'b0);
            tick();
        end
        br_busy_i = 1'b0;
        #1;
        chk("unbusy_tx_ready", tx_ready_o, 1'b1);
        tick();
        tx_valid_i = 1'b0;

        // Router withholds ack (full CAM): req and flit must hold
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("noack_br_req",  br_req_o,  1'b1);
            chk("noack_br_flit", br_flit_o, pkt_b);
            tick();
        end
        br_ack_i = 1'b1;
        #1;
        chk("ack1_br_req", br_req_o, 1'b1);
        tick();
        br_ack_i = 1'b0;
        #1;
        chk("rel_br_req",   br_req_o,   1'b0);
        chk("rel_tx_ready", tx_ready_o, 1'b0);
        tick();
        #1;
        chk("idle2_tx_ready", tx_ready_o, 1'b1);
        chk("idle2_br_req",   br_req_o,   1'b0);
        tick();

        // FIFO full: 4 requests acked, 5th stalls until a pop
        for (int k = 0; k < 4; k++) begin
            br_flit_i    = '0;
            br_flit_i.id = 8'(10 + k);
            br_req_i     = 1'b1;
            rtr_wait(4, got);
            chk($sformatf("fill%0d_acked", k), got, 1'b1);
        end
        br_flit_i    = '0;
        br_flit_i.id = 8'd14;
        br_req_i     = 1'b1;
        rtr_wait(10, got);
        chk("full_5th_acked", got, 1'b0);
        chk("full_rx_valid", rx_valid_o, 1'b1);
        rx_ready_i = 1'b1;
        #1;
        chk("full_head_id", rx_data_o.id, 8'd10);
        tick();
        rx_ready_i = 1'b0;
        rtr_wait(4, got);
        chk("after_pop_5th_acked", got, 1'b1);
        rx_ready_i = 1'b1;
        for (int k = 1; k < 5; k++) begin
            #1;
            chk($sformatf("drain%0d_valid", k), rx_valid_o, 1'b1);
            chk($sformatf("drain%0d_id", k), rx_data_o.id, 8'(10 + k));
            tick();
        end
        #1;
        chk("drained_rx_valid", rx_valid_o, 1'b0);
        rx_ready_i = 1'b0;
        tick();

        // Reset while TX in TX_REQ and RX in RX_WAIT
        tx_data_i    = pkt_a;
        tx_valid_i   = 1'b1;
        br_flit_i    = '0;
        br_flit_i.id = 8'd7;
        br_req_i     = 1'b1;
        tick();
        tx_valid_i = 1'b0;
        tick();
        #1;
        chk("pre_rst_br_req",   br_req_o,   1'b1);
        chk("pre_rst_br_ack",   br_ack_o,   1'b0);
        chk("pre_rst_rx_valid", rx_valid_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_br_req",   br_req_o,   1'b0);
        chk("mid_rst_br_ack",   br_ack_o,   1'b0);
        chk("mid_rst_rx_valid", rx_valid_o, 1'b0);
        chk("mid_rst_tx_ready", tx_ready_o, 1'b0);
        br_req_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();

        tx_data_i  = pkt_c;
        tx_valid_i = 1'b1;
        #1;
        chk("post_rst_tx_ready", tx_ready_o, 1'b1);
        tick();
        tx_valid_i = 1'b0;
        #1;
        chk("post_rst_br_req",  br_req_o,  1'b1);
        chk("post_rst_br_flit", br_flit_o, pkt_c);
        br_ack_i = 1'b1;
        tick();
        br_ack_i = 1'b0;
        #1;
        chk("post_rst_rel_req", br_req_o, 1'b0);
        tick();
        #1;
        chk("post_rst_idle_ready", tx_ready_o, 1'b1);
        br_flit_i    = '0;
        br_flit_i.id = 8'd3;
        br_req_i     = 1'b1;
        rtr_wait(4, got);
        chk("post_rst_rx_acked", got, 1'b1);
        #1;
        chk("post_rst_rx_valid", rx_valid_o, 1'b1);
        chk("post_rst_rx_id", rx_data_o.id, 8'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/brlite_local_ni.md
BRLITE_LOCAL_NI -- requirements
Module: brlite_local_ni

Interface
REQ-001 SHALL have parameter RX_DEPTH, default 4, meaning receive FIFO entries; power of 2, minimum 2.
REQ-002 SHALL have port clk_i, input, 1 bit: clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port tx_valid_i, input, 1 bit: PE has a flit to send.
REQ-005 SHALL have port tx_ready_o, output, 1 bit: NI accepts tx_data_i this cycle.
REQ-006 SHALL have port tx_data_i, input, br_data_t: PE flit to inject.
REQ-007 SHALL have port rx_valid_o, output, 1 bit: rx_data_o holds a received flit.
REQ-008 SHALL have port rx_ready_i, input, 1 bit: PE consumes rx_data_o.
REQ-009 SHALL have port rx_data_o, output, br_data_t: head of the receive FIFO.
REQ-010 SHALL have port br_flit_o, output, br_data_t: flit to the router local input.
REQ-011 SHALL have port br_req_o, output, 1 bit: request to the router local input.
REQ-012 SHALL have port br_ack_i, input, 1 bit: acknowledge from the router local input.
REQ-013 SHALL have port br_flit_i, input, br_data_t: flit from the router local output.
REQ-014 SHALL have port br_req_i, input, 1 bit: request from the router local output.
REQ-015 SHALL have port br_ack_o, output, 1 bit: acknowledge to the router local output.
REQ-016 SHALL have port br_busy_i, input, 1 bit: router local_busy; a local broadcast is still awaiting clear.

Function
REQ-017 The TX FSM SHALL use states TX_IDLE, TX_REQ and TX_RELEASE.
REQ-018 In TX_IDLE, tx_ready_o SHALL equal !br_busy_i; on tx_valid_i && tx_ready_o, the FSM SHALL latch tx_data_i into a holding register and go to TX_REQ.
REQ-019 In TX_REQ, br_req_o SHALL be 1 and br_flit_o SHALL be the holding register; the FSM SHALL go to TX_RELEASE when br_ack_i=1.
REQ-020 br_req_o SHALL be driven from a registered source; the router may drop the flit on a full CAM without acking, and br_req_o SHALL stay 1 in that case until an ack arrives, with no timeout.
REQ-021 In TX_RELEASE, br_req_o SHALL be 0 and the FSM SHALL go to TX_IDLE only when br_ack_i=0; this covers both the held-ack case and the single-cycle-ack case.
REQ-022 tx_ready_o SHALL be 0 in TX_REQ and TX_RELEASE.
REQ-023 br_flit_o SHALL hold its value from latch until the next accept.
REQ-024 The RX FSM SHALL use states RX_IDLE, RX_ACK and RX_WAIT.
REQ-025 In RX_IDLE, when br_req_i=1 and the FIFO is not full, the FSM SHALL push br_flit_i into the FIFO and go to RX_ACK; when the FIFO is full, br_ack_o SHALL stay 0 and the router stalls.
REQ-026 In RX_ACK, br_ack_o SHALL be 1 for exactly one cycle, then the FSM SHALL go to RX_WAIT.
REQ-027 In RX_WAIT, the FSM SHALL go to RX_IDLE when br_req_i=0; one router request SHALL never produce a double push.
REQ-028 rx_valid_o SHALL be 1 when the FIFO is not empty.
REQ-029 A flit pushed in cycle t SHALL be visible on rx_data_o at cycle t+1.
REQ-030 The FIFO SHALL pop on rx_valid_o && rx_ready_i; pointers SHALL be log2(RX_DEPTH)+1 bits wide, with the extra bit used for full/empty, and SHALL wrap modulo 2*RX_DEPTH.
REQ-031 Simultaneous push and pop SHALL keep the count unchanged; when full, a pop frees space for a push in the next RX_IDLE evaluation.
REQ-032 TX and RX SHALL operate independently and concurrently.

Reset
REQ-033 Reset SHALL put both FSMs in IDLE and clear the FIFO pointers.
REQ-034 During reset, br_req_o, br_ack_o, rx_valid_o and tx_ready_o SHALL be 0.
REQ-035 The holding register and FIFO data SHALL NOT require reset.
REQ-036 Reset mid-transfer SHALL abandon the transfer, with br_req_o=0 on the next cycle.

Configuration
REQ-037 Macro BRLITE_NI_STATS_EN defined SHALL add output ports tx_cnt_o[15:0] and rx_cnt_o[15:0], reset to 0.
REQ-038 With BRLITE_NI_STATS_EN defined, tx_cnt_o SHALL increment on the TX_REQ->TX_RELEASE transition, rx_cnt_o SHALL increment on each FIFO push, and both SHALL wrap at 16'hFFFF.
REQ-039 With BRLITE_NI_STATS_EN undefined, these ports and counters SHALL be absent.

Structure
REQ-040 br_data_t, br_svc_t and BR_LOCAL SHALL be used from the existing BrLitePkg.
REQ-041 A package typedef brlite_ni_tx_state_t and a package typedef brlite_ni_rx_state_t SHALL be added to BrLitePkg, one-hot encoded.
REQ-042 The receive FIFO SHALL be the sub-module brlite_fifo, with parameters DEPTH and data type br_data_t.

Verification
REQ-043 tx_valid_i=1 with service=BR_SVC_ALL, payload=16'h00AB and br_busy_i=0 -> br_req_o=1 the cycle after accept; br_ack_i held 3 cycles -> br_req_o drops after the first ack cycle, and tx_ready_o=1 only after ack=0.
REQ-044 br_busy_i=1 while tx_valid_i=1 -> tx_ready_o=0 and br_req_o stays 0 for 50 cycles; br_busy_i=0 -> accept on the next cycle.
REQ-045 Router withholds ack for 20 cycles (full CAM) -> br_req_o=1 continuously and br_flit_o stable; a 1-cycle ack -> return to TX_IDLE in 2 cycles.
REQ-046 br_req_i held 2 cycles with flit id=5 -> exactly one push, br_ack_o high for exactly 1 cycle, rx_data_o.id=5 one cycle after the push.
REQ-047 RX_DEPTH=4, rx_ready_i=0, 5 router requests -> 4 acked, 5th br_req_i unacked; one pop -> 5th acked; all 5 read out in order.
REQ-048 Assert rst_ni=0 during TX_REQ and during RX_WAIT -> br_req_o=0, br_ack_o=0 and rx_valid_o=0 immediately; normal transfer succeeds after release.
